// File: rtl/ripple_count_capture.sv
// Capture stage for an asynchronous 4-bit ripple counter: synchronizes, filters ripple
// transients, and converts accepted changes into a running total plus a delta stream.
module ripple_count_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int EXT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           count_in,
    input  logic                 clear,
    output logic [3:0]           count_stable,
    output logic                 baseline_valid,
    output logic                 update,
    output logic [EXT_WIDTH-1:0] total,
    output logic                 wrap,
    output logic [3:0]           delta,
    output logic                 delta_valid,
    input  logic                 delta_ready,
    output logic                 delta_ovf
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [3:0]         sync_q [SYNC_STAGES];
    logic [3:0]         s;
    logic [3:0]         cand;
    logic [RW-1:0]      run;
    logic [0:0]         state;

    logic               accept;
    logic               new_val;
    logic [3:0]         d;
    logic [EXT_WIDTH:0] total_sum;
    logic [4:0]         delta_sum;
    logic               xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= count_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        accept    = (s == cand) && (run == RW'(STABLE_CYCLES - 1));
        new_val   = accept && (state == ST_RUN) && (cand != count_stable);
        d         = cand - count_stable;
        total_sum = {1'b0, total} + (EXT_WIDTH + 1)'(d);
        delta_sum = {1'b0, delta} + {1'b0, d};
        xfer      = delta_valid && delta_ready;
    end

    // Run counter saturates so one stable code yields a single acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand <= '0;
            run  <= '0;
        end else if (s == cand) begin
            if (run != RW'(STABLE_CYCLES)) run <= run + 1'b1;
        end else begin
            cand <= s;
            run  <= RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_INIT;
            count_stable   <= '0;
            baseline_valid <= 1'b0;
            update         <= 1'b0;
        end else begin
            update <= new_val;
            if (accept) begin
                if (state == ST_INIT) begin
                    count_stable   <= cand;
                    baseline_valid <= 1'b1;
                    state          <= ST_RUN;
                end else if (cand != count_stable) begin
                    count_stable <= cand;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            total <= '0;
            wrap  <= 1'b0;
        end else if (new_val) begin
            total <= total_sum[EXT_WIDTH-1:0];
            wrap  <= total_sum[EXT_WIDTH];
        end else begin
            wrap <= 1'b0;
        end
    end

    // A new increment merges into an unconsumed delta, saturating at 15.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            delta       <= '0;
            delta_valid <= 1'b0;
            delta_ovf   <= 1'b0;
        end else if (new_val) begin
            if (!delta_valid || xfer) begin
                delta       <= d;
                delta_valid <= 1'b1;
            end else if (delta_sum[4]) begin
                delta     <= 4'hF;
                delta_ovf <= 1'b1;
            end else begin
                delta <= delta_sum[3:0];
            end
        end else if (xfer) begin
            delta_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Self-checking bench for ripple_count_capture: directed scenarios plus randomized
// traffic compared against a run-length / arithmetic reference model.
module tb_ripple_count_capture;

    localparam int N  = 2;
    localparam int S  = 3;
    localparam int W  = 16;
    localparam int TM = 1 << W;

    logic         clk;
    logic         rst;
    logic [3:0]   count_in;
    logic         clear;
    logic [3:0]   count_stable;
    logic         baseline_valid;
    logic         update;
    logic [W-1:0] total;
    logic         wrap;
    logic [3:0]   delta;
    logic         delta_valid;
    logic         delta_ready;
    logic         delta_ovf;

    int checks   = 0;
    int failures = 0;

    ripple_count_capture #(.SYNC_STAGES(N), .STABLE_CYCLES(S), .EXT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .clear(clear),
        .count_stable(count_stable), .baseline_valid(baseline_valid), .update(update),
        .total(total), .wrap(wrap), .delta(delta), .delta_valid(delta_valid),
        .delta_ready(delta_ready), .delta_ovf(delta_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_q[$];
    int m_last, m_runlen, m_cs, m_total, m_delta;
    bit m_base, m_upd, m_wrap, m_dv, m_ovf;

    function automatic void model_edge();
        int s, d;
        bit nv, xf;
        if (rst) begin
            m_q = {};
            for (int i = 0; i < N; i++) m_q.push_back(0);
            m_last = 0; m_runlen = 0; m_cs = 0; m_base = 0; m_total = 0;
            m_upd = 0; m_wrap = 0; m_delta = 0; m_dv = 0; m_ovf = 0;
            return;
        end
        s = m_q.pop_front();
        m_q.push_back(int'(count_in));
        if (s == m_last) m_runlen++;
        else begin
            m_last = s;
            m_runlen = 1;
        end
        nv = 0; d = 0;
        if (m_runlen == S) begin
            if (!m_base) begin
                m_cs = s;
                m_base = 1;
            end else if (s != m_cs) begin
                d = (s - m_cs + 16) % 16;
                m_cs = s;
                nv = 1;
            end
        end
        xf = m_dv && delta_ready;
        m_upd = nv;
        if (clear) begin
            m_total = 0; m_wrap = 0; m_delta = 0; m_dv = 0; m_ovf = 0;
        end else begin
            m_wrap = nv && (m_total + d >= TM);
            if (nv) m_total = (m_total + d) % TM;
            if (nv) begin
                if (!m_dv || xf) begin
                    m_delta = d;
                    m_dv = 1;
                end else if (m_delta + d > 15) begin
                    m_delta = 15;
                    m_ovf = 1;
                end else begin
                    m_delta = m_delta + d;
                end
            end else if (xf) begin
                m_dv = 0;
            end
        end
    endfunction

    function automatic logic [28:0] model_vec();
        return {m_cs[3:0], m_base, m_upd, m_total[15:0], m_wrap, m_delta[3:0], m_dv, m_ovf};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; delta_ready = 1'b0; count_in = 4'd5;
        repeat (3) step();
        checks++;
        if ({count_stable, baseline_valid, update, total, wrap, delta, delta_valid, delta_ovf} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=0",
                     {count_stable, baseline_valid, update, total, wrap, delta, delta_valid, delta_ovf});
        end
    endtask

    task automatic test_baseline();
        int upd_n;
        upd_n = 0;
        rst = 1'b0;
        repeat (4) begin
            step();
            if (update) upd_n++;
        end
        checks++;
        if (baseline_valid !== 1'b0) begin
            failures++;
            $display("FAIL baseline_early actual=%b required=0", baseline_valid);
        end
        step();
        checks++;
        if (baseline_valid !== 1'b1 || count_stable !== 4'd5) begin
            failures++;
            $display("FAIL baseline_capture actual=%b/%0d required=1/5", baseline_valid, count_stable);
        end
        repeat (3) begin
            step();
            if (update) upd_n++;
        end
        checks++;
        if (upd_n != 0 || total !== '0 || delta_valid !== 1'b0) begin
            failures++;
            $display("FAIL baseline_quiet actual=upd%0d/tot%0d/dv%b required=0/0/0", upd_n, total, delta_valid);
        end
    endtask

    task automatic test_increment();
        int upd_n, dv_n, dval;
        upd_n = 0; dv_n = 0; dval = -1;
        delta_ready = 1'b1; count_in = 4'd9;
        repeat (10) begin
            step();
            if (update) upd_n++;
            if (delta_valid) begin
                dv_n++;
                dval = int'(delta);
            end
        end
        checks++;
        if (upd_n != 1 || total !== 16'd4 || count_stable !== 4'd9) begin
            failures++;
            $display("FAIL increment_total actual=upd%0d/tot%0d/cs%0d required=1/4/9", upd_n, total, count_stable);
        end
        checks++;
        if (dv_n != 1 || dval != 4) begin
            failures++;
            $display("FAIL increment_delta actual=cycles%0d/delta%0d required=1/4", dv_n, dval);
        end
    endtask

    task automatic test_nibble_wrap();
        int t0, dval, wrap_n;
        dval = -1; wrap_n = 0;
        count_in = 4'd14;
        repeat (8) step();
        t0 = int'(total);
        count_in = 4'd2;
        repeat (8) begin
            step();
            if (delta_valid) dval = int'(delta);
            if (wrap) wrap_n++;
        end
        checks++;
        if (dval != 4 || int'(total) != (t0 + 4) % TM || wrap_n != 0 || count_stable !== 4'd2) begin
            failures++;
            $display("FAIL nibble_wrap actual=d%0d/tot%0d/w%0d/cs%0d required=4/%0d/0/2",
                     dval, total, wrap_n, count_stable, (t0 + 4) % TM);
        end
    endtask

    task automatic test_glitch();
        int t0, upd_n;
        upd_n = 0;
        count_in = 4'd9;
        repeat (8) step();
        t0 = int'(total);
        count_in = 4'd11;
        repeat (2) begin
            step();
            if (update) upd_n++;
        end
        count_in = 4'd9;
        repeat (8) begin
            step();
            if (update) upd_n++;
        end
        checks++;
        if (upd_n != 0 || count_stable !== 4'd9 || int'(total) != t0) begin
            failures++;
            $display("FAIL glitch_reject actual=upd%0d/cs%0d/tot%0d required=0/9/%0d", upd_n, count_stable, total, t0);
        end
    endtask

    task automatic test_backpressure();
        delta_ready = 1'b0;
        count_in = 4'd12; repeat (8) step();
        count_in = 4'd15; repeat (8) step();
        count_in = 4'd2;  repeat (8) step();
        checks++;
        if (delta !== 4'd9 || delta_valid !== 1'b1 || delta_ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_accumulate actual=d%0d/v%b/o%b required=9/1/0", delta, delta_valid, delta_ovf);
        end
        count_in = 4'd12; repeat (8) step();
        checks++;
        if (delta !== 4'd15 || delta_valid !== 1'b1 || delta_ovf !== 1'b1) begin
            failures++;
            $display("FAIL bp_saturate actual=d%0d/v%b/o%b required=15/1/1", delta, delta_valid, delta_ovf);
        end
        delta_ready = 1'b1;
        step();
        checks++;
        if (delta_valid !== 1'b0 || delta_ovf !== 1'b1) begin
            failures++;
            $display("FAIL bp_transfer actual=v%b/o%b required=0/1", delta_valid, delta_ovf);
        end
    endtask

    task automatic test_total_wrap_clear();
        int rem, inc, cur, wrap_n, upd_n;
        clear = 1'b1; step(); clear = 1'b0;
        checks++;
        if (total !== '0 || delta_ovf !== 1'b0 || delta_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_idle actual=tot%0d/o%b/v%b required=0/0/0", total, delta_ovf, delta_valid);
        end
        delta_ready = 1'b1;
        cur = 12; rem = 65534;
        while (rem > 0) begin
            inc = (rem >= 15) ? 15 : rem;
            cur = (cur + inc) % 16;
            count_in = 4'(cur);
            repeat (4) step();
            rem -= inc;
        end
        repeat (4) step();
        checks++;
        if (total !== 16'hFFFE) begin
            failures++;
            $display("FAIL total_preload actual=%h required=fffe", total);
        end
        cur = (cur + 4) % 16; count_in = 4'(cur); wrap_n = 0;
        repeat (8) begin
            step();
            if (wrap) wrap_n++;
        end
        checks++;
        if (wrap_n != 1 || total !== 16'h0002) begin
            failures++;
            $display("FAIL total_wrap actual=w%0d/tot%h required=1/0002", wrap_n, total);
        end
        cur = (cur + 5) % 16; count_in = 4'(cur); upd_n = 0;
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (update !== 1'b1 || int'(count_stable) != cur || total !== '0 || delta_valid !== 1'b0 || delta !== 4'd0) begin
            failures++;
            $display("FAIL clear_on_accept actual=u%b/cs%0d/tot%0d/v%b/d%0d required=1/%0d/0/0/0",
                     update, count_stable, total, delta_valid, delta, cur);
        end
        repeat (3) begin
            step();
            if (update) upd_n++;
        end
        checks++;
        if (upd_n != 0 || delta_valid !== 1'b0 || total !== '0) begin
            failures++;
            $display("FAIL clear_after actual=u%0d/v%b/tot%0d required=0/0/0", upd_n, delta_valid, total);
        end
    endtask

    task automatic test_random();
        int hold;
        logic [28:0] act;
        hold = 0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                count_in = 4'($urandom);
                hold = $urandom_range(1, 6);
            end
            hold--;
            delta_ready = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 23) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            act = {count_stable, baseline_valid, update, total, wrap, delta, delta_valid, delta_ovf};
            checks++;
            if (act !== model_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d actual=%h required=%h", i, act, model_vec());
            end
        end
        rst = 1'b0; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_increment();
        test_nibble_wrap();
        test_glitch();
        test_backpressure();
        test_total_wrap_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Clock-domain capture stage downstream of the 4-bit ripple counter. It synchronizes the counter's asynchronous, rippling `count_in` nibble into `clk` and rejects transient ripple codes with a stability filter. Each accepted change becomes a modulo-16 increment that drives a wide running total and a valid/ready delta stream for the next consumer.

## Interface
- `SYNC_STAGES`, 2: flop stages per bit in the input synchronizer (≥2).
- `STABLE_CYCLES`, 3: consecutive identical synchronized samples required before acceptance (≥2).
- `EXT_WIDTH`, 16: width of the extended running total.

- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `count_in`, in, 4: ripple counter output; asynchronous to `clk`.
- `clear`, in, 1: synchronous clear of total and delta path.
- `count_stable`, out, 4: last accepted counter value.
- `baseline_valid`, out, 1: high once the first stable value has been captured.
- `update`, out, 1: one-cycle pulse when a new value is accepted after baseline.
- `total`, out, EXT_WIDTH: running sum of accepted increments, modulo 2^EXT_WIDTH.
- `wrap`, out, 1: one-cycle pulse when `total` carries out.
- `delta`, out, 4: pending increment, 1..15.
- `delta_valid`, out, 1: `delta` holds an unconsumed increment.
- `delta_ready`, in, 1: consumer accepts `delta`.
- `delta_ovf`, out, 1: sticky flag; pending delta saturated.

## Operation
- Reset values: all outputs are 0. The filter candidate and run counter are 0, and the state is INIT.
- Synchronizer: `count_in` passes through SYNC_STAGES flops per bit, producing sample `s`.
- Filter, every cycle:
  - If `s == cand`, `run` increments, saturating at STABLE_CYCLES.
  - Otherwise `cand <= s` and `run <= 1`.
  - Acceptance occurs at the edge where `run` becomes STABLE_CYCLES.
- INIT state: on acceptance, `count_stable <= cand` and `baseline_valid <= 1`, then go to RUN. There is no `update`, no delta, and no `total` change.
- RUN state: acceptance with `cand != count_stable` is a new value.
  - `d = (cand - count_stable) mod 16`, range 1..15.
  - `count_stable <= cand` and `update` pulses.
  - `total <= total + d`. `wrap` pulses if the sum overflows EXT_WIDTH.
- Acceptance with `cand == count_stable` has no effect.
- Delta stream:
  - With no pending delta, load `delta = d` and set `delta_valid`.
  - A transfer occurs when `delta_valid && delta_ready`.
  - Transfer with no new `d`: `delta_valid <= 0`.
  - Transfer in the same cycle as a new `d`: `delta <= d`, `delta_valid` stays 1.
  - Valid, not ready, new `d`: `delta <= min(delta + d, 15)`. Set `delta_ovf` if the true sum exceeds 15.
  - `delta` and `delta_valid` are stable while not accepted.
- `clear`, checked after `rst`:
  - Forces `total = 0`, `delta_valid = 0`, `delta = 0`, `delta_ovf = 0`, `wrap = 0`.
  - An acceptance in the same cycle still updates `count_stable` and pulses `update`, but its `d` is discarded.
  - `clear` does not touch the filter, state or baseline.
- `rst` at any point, including mid-filter or with a delta pending, returns all state to reset values. After release, a new baseline is captured in INIT.

## Timing
- Acceptance latency: `count_in` constant from the first sampling edge (edge 1) is accepted at edge SYNC_STAGES+STABLE_CYCLES. With defaults that is edge 5.
  - `count_stable`, `update`, `total` and `delta_valid` are visible in the cycle after that edge.
- Glitch rejection: a synchronized code persisting fewer than STABLE_CYCLES samples is never accepted.
- `update` and `wrap` are exactly one cycle wide. Back-to-back acceptances are at least STABLE_CYCLES cycles apart.
- `delta_valid` may deassert only in the cycle after a transfer, or on `clear`/`rst`.
- No combinational path from any input to any output.

## Test plan
- Baseline: assert `rst`, hold `count_in=5`, release. By edge 5 `count_stable=5` and `baseline_valid=1`. `update`, `total` and `delta_valid` stay 0.
- Increment: from baseline 5, set `count_in=9` with `delta_ready=1`. Expect one `update` pulse, `total=4`, and `delta=4` valid for one cycle.
- Nibble wrap: stable 14, then `count_in=2`. Expect `delta=4` and `total` +4. `wrap` stays 0.
- Glitch: stable 9, drive `count_in=11` for 2 cycles, then back to 9. Expect no `update`, `count_stable=9`, and `total` unchanged.
- Backpressure: `delta_ready=0`, accept increments +3, +3, +3, giving `delta=9`. Then +10 gives `delta=15` and `delta_ovf=1`. Raising `delta_ready` gives one transfer of 15, after which `delta_valid=0`.
- Total wrap and clear: `total=0xFFFE`, increment +4 gives `total=0x0002` with a one-cycle `wrap`. Then assert `clear` in the same cycle as an acceptance: `total=0`, `update` pulses, `count_stable` updated, no delta.
